// File: rtl/bp_fe_ras_circ_if.sv
// Return-address-stack port bundle: frontend (master) drives push/pop/restore,
// RAS (slave) returns the predicted target and its checkpoint state.
interface bp_fe_ras_circ_if #(
    parameter int vaddr_width_p = 39,
    parameter int ras_els_p     = 16
);
    localparam int ptr_width_lp = $clog2(ras_els_p);
    localparam int cnt_width_lp = $clog2(ras_els_p + 1);

    logic                     push_i;
    logic [vaddr_width_p-1:0] push_addr_i;
    logic                     pop_i;
    logic                     restore_i;
    logic [ptr_width_lp-1:0]  restore_ptr_i;
    logic [cnt_width_lp-1:0]  restore_cnt_i;
    logic [vaddr_width_p-1:0] tgt_o;
    logic                     tgt_v_o;
    logic [ptr_width_lp-1:0]  ckpt_ptr_o;
    logic [cnt_width_lp-1:0]  ckpt_cnt_o;

    modport master (
        output push_i, push_addr_i, pop_i, restore_i, restore_ptr_i, restore_cnt_i,
        input  tgt_o, tgt_v_o, ckpt_ptr_o, ckpt_cnt_o
    );

    modport slave (
        input  push_i, push_addr_i, pop_i, restore_i, restore_ptr_i, restore_cnt_i,
        output tgt_o, tgt_v_o, ckpt_ptr_o, ckpt_cnt_o
    );
endinterface

// File: rtl/bp_fe_ras_circ.sv
// Circular return address stack with saturating occupancy.
// Oldest entries are silently overwritten on overflow; pops on an empty stack
// are dropped. Checkpoint restore is built only with BP_FE_RAS_RESTORE_EN.
module bp_fe_ras_circ #(
    parameter int vaddr_width_p = 39,
    parameter int ras_els_p     = 16
) (
    input logic               clk_i,
    input logic               reset_i,
    bp_fe_ras_circ_if.slave   ras_if
);
    localparam int ptr_width_lp = $clog2(ras_els_p);
    localparam int cnt_width_lp = $clog2(ras_els_p + 1);
    localparam logic [cnt_width_lp-1:0] full_lp = cnt_width_lp'(ras_els_p);

    logic [ras_els_p-1:0][vaddr_width_p-1:0] mem_r;
    logic [ptr_width_lp-1:0] tp_r, tp_n, wr_idx;
    logic [cnt_width_lp-1:0] cnt_r, cnt_n;
    logic                    wr_en;

    // Next pointer/occupancy and write target; restore (when built) overrides push/pop
    always_comb begin
        tp_n   = tp_r;
        cnt_n  = cnt_r;
        wr_en  = 1'b0;
        wr_idx = tp_r;
        if (ras_if.push_i && ras_if.pop_i) begin
            // co-routine swap: replace top in place
            wr_en = 1'b1;
            if (cnt_r == '0) cnt_n = cnt_width_lp'(1);
        end else if (ras_if.push_i) begin
            tp_n   = tp_r + 1'b1;
            wr_en  = 1'b1;
            wr_idx = tp_n;
            if (cnt_r != full_lp) cnt_n = cnt_r + 1'b1;
        end else if (ras_if.pop_i && cnt_r != '0) begin
            tp_n  = tp_r - 1'b1;
            cnt_n = cnt_r - 1'b1;
        end
`ifdef BP_FE_RAS_RESTORE_EN
        if (ras_if.restore_i) begin
            wr_en = 1'b0;
            tp_n  = ras_if.restore_ptr_i;
            cnt_n = (ras_if.restore_cnt_i > full_lp) ? full_lp : ras_if.restore_cnt_i;
        end
`endif
    end

`ifndef BP_FE_RAS_RESTORE_EN
    // restore port is present but intentionally dead in this build
    logic unused_restore;
    assign unused_restore = ^{ras_if.restore_i, ras_if.restore_ptr_i, ras_if.restore_cnt_i};
`endif

    // Pointer and occupancy state
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tp_r  <= '0;
            cnt_r <= '0;
        end else begin
            tp_r  <= tp_n;
            cnt_r <= cnt_n;
        end
    end

    // Entry storage; reset clears every entry so tgt_o reads zero afterwards
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem_r <= '0;
        end else if (wr_en) begin
            mem_r[wr_idx] <= ras_if.push_addr_i;
        end
    end

    assign ras_if.tgt_o      = mem_r[tp_r];
    assign ras_if.tgt_v_o    = (cnt_r != '0);
    assign ras_if.ckpt_ptr_o = tp_r;
    assign ras_if.ckpt_cnt_o = cnt_r;
endmodule

// File: tb/tb_bp_fe_ras_circ.sv
// Scoreboard bench for bp_fe_ras_circ (ras_els_p=4): a reference stack model
// queues the expected post-edge state for each driven op, checked one edge later.
module tb_bp_fe_ras_circ;
    localparam int VW = 39;
    localparam int N  = 4;
`ifdef BP_FE_RAS_RESTORE_EN
    localparam bit RESTORE_EN = 1'b1;
`else
    localparam bit RESTORE_EN = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    bp_fe_ras_circ_if #(.vaddr_width_p(VW), .ras_els_p(N)) ras_if ();

    bp_fe_ras_circ #(.vaddr_width_p(VW), .ras_els_p(N)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ras_if  (ras_if)
    );

    typedef struct {
        logic [VW-1:0] tgt;
        logic          v;
        logic [1:0]    ptr;
        logic [2:0]    cnt;
    } exp_t;

    exp_t          sb[$];
    logic [VW-1:0] m_mem[N];
    int            m_tp, m_cnt;
    int            checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        m_tp  = 0;
        m_cnt = 0;
    endtask

    task automatic idle_inputs();
        ras_if.push_i        = 1'b0;
        ras_if.push_addr_i   = '0;
        ras_if.pop_i         = 1'b0;
        ras_if.restore_i     = 1'b0;
        ras_if.restore_ptr_i = '0;
        ras_if.restore_cnt_i = '0;
    endtask

    // drive one op, update the model, queue expected state, check after the edge
    task automatic step(input bit push, input logic [VW-1:0] a, input bit pop,
                        input bit rs, input int rp, input int rc);
        exp_t e, o;
        ras_if.push_i        = push;
        ras_if.push_addr_i   = a;
        ras_if.pop_i         = pop;
        ras_if.restore_i     = rs;
        ras_if.restore_ptr_i = 2'(rp);
        ras_if.restore_cnt_i = 3'(rc);
        if (rs && RESTORE_EN) begin
            m_tp  = rp;
            m_cnt = (rc > N) ? N : rc;
        end else if (push && pop) begin
            m_mem[m_tp] = a;
            if (m_cnt == 0) m_cnt = 1;
        end else if (push) begin
            m_tp = (m_tp + 1) % N;
            m_mem[m_tp] = a;
            if (m_cnt < N) m_cnt++;
        end else if (pop && m_cnt > 0) begin
            m_tp = (m_tp + N - 1) % N;
            m_cnt--;
        end
        e.tgt = m_mem[m_tp];
        e.v   = (m_cnt != 0);
        e.ptr = 2'(m_tp);
        e.cnt = 3'(m_cnt);
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        o = sb.pop_front();
        chk("sb_tgt", 64'(ras_if.tgt_o), 64'(o.tgt));
        chk("sb_v",   64'(ras_if.tgt_v_o), 64'(o.v));
        chk("sb_ptr", 64'(ras_if.ckpt_ptr_o), 64'(o.ptr));
        chk("sb_cnt", 64'(ras_if.ckpt_cnt_o), 64'(o.cnt));
        idle_inputs();
    endtask

    task automatic push_op(input logic [VW-1:0] a); step(1, a, 0, 0, 0, 0); endtask
    task automatic pop_op();                        step(0, '0, 1, 0, 0, 0); endtask

    task automatic do_reset();
        reset_i = 1'b1;
        model_clear();
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        chk("rst_tgt", 64'(ras_if.tgt_o), 64'h0);
        chk("rst_v",   64'(ras_if.tgt_v_o), 64'h0);
        chk("rst_ptr", 64'(ras_if.ckpt_ptr_o), 64'h0);
        chk("rst_cnt", 64'(ras_if.ckpt_cnt_o), 64'h0);
    endtask

    initial begin
        idle_inputs();
        model_clear();
        reset_i = 1'b1;
        #1;
        chk("async_rst_v", 64'(ras_if.tgt_v_o), 64'h0);
        do_reset();

        // push then pop
        push_op(39'h100);
        chk("pp_tgt", 64'(ras_if.tgt_o), 64'h100);
        chk("pp_v",   64'(ras_if.tgt_v_o), 64'h1);
        pop_op();
        chk("pp_pop_v",   64'(ras_if.tgt_v_o), 64'h0);
        chk("pp_pop_cnt", 64'(ras_if.ckpt_cnt_o), 64'h0);

        // underflow leaves state alone
        pop_op();
        chk("uf_ptr", 64'(ras_if.ckpt_ptr_o), 64'h0);
        chk("uf_cnt", 64'(ras_if.ckpt_cnt_o), 64'h0);
        chk("uf_v",   64'(ras_if.tgt_v_o), 64'h0);

        // overflow wraps over the oldest entry
        do_reset();
        for (int i = 1; i <= 5; i++) push_op(VW'(i * 16));
        chk("ovf_cnt", 64'(ras_if.ckpt_cnt_o), 64'h4);
        chk("ovf_tgt", 64'(ras_if.tgt_o), 64'h50);
        pop_op(); chk("ovf_pop1", 64'(ras_if.tgt_o), 64'h40);
        pop_op(); chk("ovf_pop2", 64'(ras_if.tgt_o), 64'h30);
        pop_op(); chk("ovf_pop3", 64'(ras_if.tgt_o), 64'h20);
        pop_op(); chk("ovf_pop4_v", 64'(ras_if.tgt_v_o), 64'h0);

        // co-routine swap
        do_reset();
        push_op(39'h10);
        push_op(39'h20);
        step(1, 39'h99, 1, 0, 0, 0);
        chk("swap_tgt", 64'(ras_if.tgt_o), 64'h99);
        chk("swap_cnt", 64'(ras_if.ckpt_cnt_o), 64'h2);
        pop_op();
        chk("swap_pop", 64'(ras_if.tgt_o), 64'h10);

        // checkpoint / restore with a competing push
        do_reset();
        step(1, 39'h60, 1, 0, 0, 0);   // swap on empty: cnt=1, tp=0
        push_op(39'h61);
        chk("ck_ptr", 64'(ras_if.ckpt_ptr_o), 64'h1);
        chk("ck_cnt", 64'(ras_if.ckpt_cnt_o), 64'h2);
        push_op(39'h70);
        pop_op();
        pop_op();
        step(1, 39'hEE, 0, 1, 1, 2);
`ifdef BP_FE_RAS_RESTORE_EN
        chk("rs_ptr", 64'(ras_if.ckpt_ptr_o), 64'h1);
        chk("rs_cnt", 64'(ras_if.ckpt_cnt_o), 64'h2);
        chk("rs_tgt", 64'(ras_if.tgt_o), 64'h61);
        step(0, '0, 1, 1, 3, 7);
        chk("rs_clamp", 64'(ras_if.ckpt_cnt_o), 64'h4);
`else
        chk("nors_ptr", 64'(ras_if.ckpt_ptr_o), 64'h1);
        chk("nors_cnt", 64'(ras_if.ckpt_cnt_o), 64'h2);
        chk("nors_tgt", 64'(ras_if.tgt_o), 64'hEE);
`endif

        // asynchronous reset in the middle of a push burst
        do_reset();
        push_op(39'h10);
        push_op(39'h20);
        ras_if.push_i      = 1'b1;
        ras_if.push_addr_i = 39'h30;
        #2;
        reset_i = 1'b1;
        #1;
        chk("mid_rst_v",   64'(ras_if.tgt_v_o), 64'h0);
        chk("mid_rst_tgt", 64'(ras_if.tgt_o), 64'h0);
        chk("mid_rst_cnt", 64'(ras_if.ckpt_cnt_o), 64'h0);
        @(posedge clk_i);
        #1;
        chk("rst_hold_cnt", 64'(ras_if.ckpt_cnt_o), 64'h0);
        idle_inputs();
        do_reset();

        // random mix against the model
        for (int i = 0; i < 300; i++) begin
            bit rs;
            rs = ($urandom_range(0, 15) == 0);
            step(1'($urandom_range(0, 1)), VW'({$urandom(), $urandom()}),
                 1'($urandom_range(0, 1)), rs,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
